// File: rtl/key_event_uart_tx.sv
// key_event_uart_tx
//
// Turns keyboard/encoder event codes into UART 8N1 frames for a host MCU.
// A new event is taken when keyEventReady is high and the code differs from
// the code seen on the previous cycle, so a level that is held produces one
// event only. Events wait in a small FIFO and the transmitter sends them in
// arrival order, LSB first.
//
// Parameters
//   CLK_DIV     clock cycles per UART bit (2..65535)
//   FIFO_DEPTH  event FIFO entries (power of two, 2..16)
//
// Ports
//   clk            single clock, everything changes on its rising edge
//   rst            synchronous active-high reset; aborts any frame in flight
//                  and empties the FIFO
//   keyEventReady  event code on keyEvent is valid
//   keyEvent       bit7 released/CCW, bit6 pressed/CW, bits5:0 key code
//   txd            serial line, idle high, driven from a register
//   busy           a frame is on the line or events are still queued
//   fifoOverflow   sticky: at least one event was dropped (cleared by rst)
//   fifoCount      FIFO occupancy, 0..FIFO_DEPTH

module key_event_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       keyEventReady,
  input  logic [7:0] keyEvent,
  output logic       txd,
  output logic       busy,
  output logic       fifoOverflow,
  output logic [4:0] fifoCount
);

  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [4:0]  COUNT_MAX = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [7:0]       prev_event_reg;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [4:0]       count_reg;
  logic             overflow_reg;

  state_t           state_reg;
  logic [15:0]      baud_reg;
  logic [2:0]       bit_reg;
  logic [7:0]       shift_reg;
  logic             txd_reg;
  logic             busy_reg;

  // ---------------------------------------------------------------------
  // Capture / FIFO control
  // ---------------------------------------------------------------------
  logic capture;
  logic full;
  logic pop;
  logic push;

  always_comb begin
    capture = keyEventReady && (keyEvent != prev_event_reg);
    full    = (count_reg == COUNT_MAX);
    // The transmitter takes the head during its single IDLE cycle.
    pop     = (state_reg == IDLE) && (count_reg != 5'd0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push    = capture && (!full || pop);
  end

  // Storage has no reset so it maps onto plain RAM; the pointers define
  // which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= keyEvent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_event_reg <= 8'h00;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= 5'd0;
      overflow_reg   <= 1'b0;
    end else begin
      prev_event_reg <= keyEvent;

      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_reg <= count_reg + 5'd1;
        2'b01:   count_reg <= count_reg - 5'd1;
        default: count_reg <= count_reg;
      endcase

      if (capture && full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  //
  // txd is registered from the current state, so the line lags the state
  // by one cycle: capture edge -> pop edge (state START) -> txd low.
  // Each state/bit lasts CLK_DIV cycles, which keeps the line timing exact
  // while still giving one full IDLE cycle between frames.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      baud_reg  <= 16'd0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'h00;
      txd_reg   <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      busy_reg <= (state_reg != IDLE) || (count_reg != 5'd0);

      case (state_reg)
        IDLE: begin
          txd_reg  <= 1'b1;
          baud_reg <= 16'd0;
          bit_reg  <= 3'd0;
          if (pop) begin
            shift_reg <= mem[rd_ptr_reg];
            state_reg <= START;
          end
        end

        START: begin
          txd_reg <= 1'b0;
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= 16'd0;
            bit_reg   <= 3'd0;
            state_reg <= DATA;
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end

        DATA: begin
          // Shift right at each bit boundary so bit 0 is always the next
          // bit to go out.
          txd_reg <= shift_reg[0];
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= 16'd0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_reg == 3'd7) begin
              bit_reg   <= 3'd0;
              state_reg <= STOP;
            end else begin
              bit_reg <= bit_reg + 3'd1;
            end
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end

        STOP: begin
          txd_reg <= 1'b1;
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= 16'd0;
            state_reg <= IDLE;
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end

        default: begin
          txd_reg   <= 1'b1;
          baud_reg  <= 16'd0;
          bit_reg   <= 3'd0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign txd          = txd_reg;
  assign busy         = busy_reg;
  assign fifoOverflow = overflow_reg;
  assign fifoCount    = count_reg;

endmodule

// File: tb/tb_key_event_uart_tx.sv
// tb_key_event_uart_tx
//
// Directed bench for key_event_uart_tx with CLK_DIV=4, FIFO_DEPTH=8.
// A background receiver decodes frames from txd (sampling mid-bit on the
// falling clock edge) and records each byte with the cycle its start bit
// first appeared. Single-event cases come from a vector table; bursts,
// FIFO-full corner cases and mid-frame reset are hand-written sequences.

module tb_key_event_uart_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME_GAP  = 10 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       keyEventReady;
  logic [7:0] keyEvent;
  logic       txd;
  logic       busy;
  logic       fifoOverflow;
  logic [4:0] fifoCount;

  key_event_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .keyEventReady (keyEventReady),
    .keyEvent      (keyEvent),
    .txd           (txd),
    .busy          (busy),
    .fifoOverflow  (fifoOverflow),
    .fifoCount     (fifoCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         framing_ok;
  } frame_t;

  frame_t frames[$];
  int     aborts = 0;

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  task automatic mon_wait(input int n, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) hit = 1'b1;
    end
  endtask

  initial begin
    frame_t     f;
    bit         hit;
    bit         h2;
    bit         ok;
    logic [7:0] d;
    int         s;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        s = cyc;
        d = 8'h00;
        mon_wait(CLK_DIV / 2, hit);
        ok = (txd === 1'b0);
        for (int k = 0; k < 8; k++) begin
          mon_wait(CLK_DIV, h2);
          hit  = hit | h2;
          d[k] = txd;
        end
        mon_wait(CLK_DIV, h2);
        hit = hit | h2;
        ok  = ok && (txd === 1'b1);
        if (hit) begin
          aborts++;
        end else begin
          f.data       = d;
          f.start      = s;
          f.framing_ok = ok;
          frames.push_back(f);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // exp_start < 0 skips the timing comparison.
  task automatic get_frame(input string nm, input logic [7:0] exp_byte, input int exp_start);
    frame_t f;
    chk({nm, "_present"}, 32'(frames.size() != 0), 32'd1);
    if (frames.size() != 0) begin
      f = frames.pop_front();
      $display("frame %s: byte=0x%02h start=%0d", nm, f.data, f.start);
      chk({nm, "_byte"}, 32'(f.data), 32'(exp_byte));
      chk({nm, "_framing"}, 32'(f.framing_ok), 32'd1);
      if (exp_start >= 0) chk({nm, "_start"}, 32'(f.start), 32'(exp_start));
    end
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n;
    repeat (3) @(negedge clk);
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Drive one event for exactly one cycle; returns the capture edge cycle.
  task automatic send1(input logic [7:0] code, output int cap);
    keyEventReady = 1'b1;
    keyEvent      = code;
    cap           = cyc + 1;
    @(negedge clk);
  endtask

  task automatic quiet();
    keyEventReady = 1'b0;
    keyEvent      = 8'h00;
  endtask

  // ---------------------------------------------------------------------
  // Vector table for single-event behaviour
  // ---------------------------------------------------------------------
  typedef struct {
    bit         rdy;
    logic [7:0] code;
    int         hold;
    int         nframes;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cap;
    int c0;
    int s3;
    int nfr;
    int fall;

    vecs[0] = '{rdy: 1'b1, code: 8'h45, hold: 100, nframes: 1};
    vecs[1] = '{rdy: 1'b0, code: 8'h5A, hold: 30,  nframes: 0};
    vecs[2] = '{rdy: 1'b1, code: 8'h81, hold: 60,  nframes: 1};
    vecs[3] = '{rdy: 1'b1, code: 8'h3C, hold: 3,   nframes: 1};
    vecs[4] = '{rdy: 1'b0, code: 8'hC3, hold: 20,  nframes: 0};
    vecs[5] = '{rdy: 1'b1, code: 8'hA7, hold: 1,   nframes: 1};

    rst = 1'b1;
    quiet();
    repeat (5) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(fifoOverflow), 32'd0);
    chk("rst_count", 32'(fifoCount), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table: held levels capture once, ready=0 never captures.
    for (int v = 0; v < 6; v++) begin
      cap = cyc + 1;
      for (int i = 0; i < vecs[v].hold; i++) begin
        keyEventReady = vecs[v].rdy;
        keyEvent      = vecs[v].rdy ? vecs[v].code : (vecs[v].code ^ 8'(i));
        @(negedge clk);
      end
      if (!vecs[v].rdy) begin
        chk($sformatf("v%0d_count", v), 32'(fifoCount), 32'd0);
        chk($sformatf("v%0d_txd", v), 32'(txd), 32'd1);
      end
      quiet();
      wait_idle($sformatf("v%0d", v), 300);
      chk($sformatf("v%0d_nframes", v), 32'(frames.size()), 32'(vecs[v].nframes));
      if (vecs[v].nframes == 1) get_frame($sformatf("v%0d", v), vecs[v].code, cap + 2);
      frames.delete();
      chk($sformatf("v%0d_count_end", v), 32'(fifoCount), 32'd0);
    end

    // Three captures on consecutive cycles: frames 41 cycles apart.
    send1(8'h41, c0);
    send1(8'h81, cap);
    send1(8'h43, cap);
    quiet();
    s3 = c0 + 2 + 2 * FRAME_GAP;
    fall = -1;
    for (int i = 0; i < 300 && fall < 0; i++) begin
      @(negedge clk);
      if (cyc == s3 + 39) chk("burst_busy_before_fall", 32'(busy), 32'd1);
      if (busy === 1'b0 && cyc > c0 + 3) fall = cyc;
    end
    chk("burst_busy_fall", 32'(fall), 32'(s3 + 40));
    get_frame("burst0", 8'h41, c0 + 2);
    get_frame("burst1", 8'h81, c0 + 2 + FRAME_GAP);
    get_frame("burst2", 8'h43, s3);

    // Full FIFO with a capture landing on the IDLE pop edge.
    send1(8'h20, c0);
    for (int i = 1; i <= 8; i++) send1(8'h20 + 8'(i), cap);
    quiet();
    while (cyc < c0 + 41) @(negedge clk);
    chk("full_count_before", 32'(fifoCount), 32'd8);
    send1(8'h77, cap);
    quiet();
    chk("full_cap_edge", 32'(cap), 32'(c0 + 42));
    chk("full_count_after", 32'(fifoCount), 32'd8);
    chk("full_ovf", 32'(fifoOverflow), 32'd0);
    wait_idle("full", 1000);
    nfr = frames.size();
    chk("full_nframes", 32'(nfr), 32'd10);
    for (int i = 0; i <= 8; i++) get_frame($sformatf("full%0d", i), 8'h20 + 8'(i), c0 + 2 + i * FRAME_GAP);
    get_frame("full_last", 8'h77, c0 + 2 + 9 * FRAME_GAP);
    frames.delete();

    // Ten captures during the first frame: the tenth is dropped.
    for (int i = 0; i < 9; i++) send1(8'h10 + 8'(i), cap);
    chk("ovf_before_drop", 32'(fifoOverflow), 32'd0);
    chk("count_full", 32'(fifoCount), 32'd8);
    send1(8'h19, cap);
    quiet();
    chk("ovf_after_drop", 32'(fifoOverflow), 32'd1);
    chk("count_after_drop", 32'(fifoCount), 32'd8);
    wait_idle("drop", 1000);
    chk("drop_nframes", 32'(frames.size()), 32'd9);
    for (int i = 0; i < 9; i++) get_frame($sformatf("drop%0d", i), 8'h10 + 8'(i), -1);
    frames.delete();
    chk("ovf_sticky", 32'(fifoOverflow), 32'd1);

    // Reset during DATA bit 3 aborts the frame and flushes the queue.
    send1(8'h5A, c0);
    send1(8'h3C, cap);
    quiet();
    while (cyc < c0 + 18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_txd", 32'(txd), 32'd1);
    chk("mid_rst_count", 32'(fifoCount), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ovf", 32'(fifoOverflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_rst_noframes", 32'(frames.size()), 32'd0);
    chk("mid_rst_aborts", 32'(aborts), 32'd1);
    send1(8'h99, c0);
    quiet();
    wait_idle("after_rst", 300);
    get_frame("after_rst", 8'h99, c0 + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
